// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the external 512K x 8 async
// SRAM controller.
//   state_t        : controller FSM state encoding
//   SRAM_ADDR_W/_DATA_W : pin widths of the attached device
//   RD/WR_CYCLES_DEF    : wait states that meet 45 ns access at 100 MHz
package sram_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    TURN  = 2'd3
  } state_t;

  localparam int SRAM_ADDR_W   = 19;
  localparam int SRAM_DATA_W   = 8;
  localparam int RD_CYCLES_DEF = 5;
  localparam int WR_CYCLES_DEF = 5;

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-beat valid/ready requests into timed pin cycles
// for an asynchronous SRAM (active-low ce_b/we_b/oe_b, shared data bus).
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake (ready only while IDLE)
//   req_we/addr/wdata   : request fields, sampled only at the handshake
//   rd_data/rd_valid    : read result and its one-cycle update pulse
//   sram_*              : registered SRAM pins; sram_data driven only in WRITE
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W    = SRAM_ADDR_W,
  parameter int DATA_W    = SRAM_DATA_W,
  parameter int RD_CYCLES = RD_CYCLES_DEF,
  parameter int WR_CYCLES = WR_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              sram_ce_b,
  output logic              sram_we_b,
  output logic              sram_oe_b,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  // Reads sample on a registered edge, so they need at least two held cycles.
  if (RD_CYCLES < 2 || WR_CYCLES < 1) begin : g_bad_cycles
    $error("sram_ctrl: RD_CYCLES must be >= 2 and WR_CYCLES >= 1");
  end

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC);
  localparam logic [CNT_W-1:0] RD_LD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LD = CNT_W'(WR_CYCLES - 1);

  state_t             r_state, w_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic               w_accept;
  logic               w_rd_done;

  logic               r_ce_b, r_we_b, r_oe_b, r_drive;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata, r_rd_data;
  logic               r_rd_valid;

  assign req_ready = (r_state == IDLE);
  assign w_rd_done = (r_state == READ) && (w_nxt == TURN);

  always_comb begin
    w_nxt     = r_state;
    w_cnt_nxt = r_cnt;
    w_accept  = 1'b0;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_accept  = 1'b1;
          w_nxt     = req_we ? WRITE : READ;
          w_cnt_nxt = req_we ? WR_LD : RD_LD;
        end
      end
      WRITE, READ: begin
        if (r_cnt == '0) w_nxt = TURN;
        else             w_cnt_nxt = r_cnt - 1'b1;
      end
      TURN:    w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // Pins are registered from the next state so they switch on the same edge
  // the FSM changes; in particular WRITE->TURN releases we_b and the data bus
  // together and the SRAM latches the values held up to that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ce_b     <= 1'b1;
      r_we_b     <= 1'b1;
      r_oe_b     <= 1'b1;
      r_drive    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_state    <= w_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ce_b     <= !((w_nxt == WRITE) || (w_nxt == READ));
      r_we_b     <= (w_nxt != WRITE);
      r_oe_b     <= (w_nxt != READ);
      r_drive    <= (w_nxt == WRITE);
      r_rd_valid <= w_rd_done;
      if (w_accept) begin
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (w_rd_done) r_rd_data <= sram_data;
    end
  end

  assign sram_ce_b = r_ce_b;
  assign sram_we_b = r_we_b;
  assign sram_oe_b = r_oe_b;
  assign sram_addr = r_addr;
  assign sram_data = r_drive ? r_wdata : {DATA_W{1'bz}};
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;

endmodule

// File: tb/tb_sram_ctrl.sv
module tb_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Index 0: default timing (5/5). Index 1: minimum timing (RD=2, WR=1).
  logic [1:0]        rst;
  logic [1:0]        rq_valid, rq_we;
  logic [1:0][18:0]  rq_addr;
  logic [1:0][7:0]   rq_wdata;
  wire  [1:0]        rdy, rv, ce_b, we_b, oe_b;
  wire  [1:0][7:0]   rdd;
  wire  [1:0][18:0]  saddr;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    wire  [7:0] sdat;
    logic [7:0] mem [0:524287];
    int         mon_bad = 0;

    sram_ctrl #(
      .ADDR_W(19), .DATA_W(8),
      .RD_CYCLES(g == 0 ? 5 : 2),
      .WR_CYCLES(g == 0 ? 5 : 1)
    ) u_dut (
      .clk(clk), .rst(rst[g]),
      .req_valid(rq_valid[g]), .req_ready(rdy[g]), .req_we(rq_we[g]),
      .req_addr(rq_addr[g]), .req_wdata(rq_wdata[g]),
      .rd_data(rdd[g]), .rd_valid(rv[g]),
      .sram_ce_b(ce_b[g]), .sram_we_b(we_b[g]), .sram_oe_b(oe_b[g]),
      .sram_addr(saddr[g]), .sram_data(sdat)
    );

    // Async SRAM model: drives the bus on a read, captures while we_b low.
    initial for (int i = 0; i < 524288; i++) mem[i] = 8'h00;
    assign sdat = (!ce_b[g] && !oe_b[g] && we_b[g]) ? mem[saddr[g]] : 8'bz;
    always @(posedge clk) if (!ce_b[g] && !we_b[g]) mem[saddr[g]] <= sdat;

    // Bus ownership: controller drives only with we_b low, so oe_b and we_b
    // must never be low together, and neither may be low without ce_b.
    always @(negedge clk) begin
      if (!oe_b[g] && !we_b[g]) mon_bad <= mon_bad + 1;
      if ((!oe_b[g] || !we_b[g]) && ce_b[g]) mon_bad <= mon_bad + 1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] sb [logic [18:0]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // One access: handshake, then watch cycles k=1.. after E0 until req_ready.
  task automatic run_access(input int d, input bit w, input logic [18:0] a,
                            input logic [7:0] wdat, output logic [7:0] rdo,
                            output int rv_k, output int ready_k,
                            output int we_low, output int oe_low,
                            output logic [18:0] a_seen);
    int n;
    rdo = 8'h00; rv_k = 0; ready_k = 0; we_low = 0; oe_low = 0; a_seen = '0;
    @(negedge clk);
    rq_valid[d] = 1'b1; rq_we[d] = w; rq_addr[d] = a; rq_wdata[d] = wdat;
    n = 0;
    while (!rdy[d] && n < 50) begin @(negedge clk); n++; end
    if (!rdy[d]) begin
      chk("handshake_timeout", 32'd1, 32'd0);
      rq_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    rq_valid[d] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) a_seen = saddr[d];
      if (!we_b[d]) we_low++;
      if (!oe_b[d]) oe_low++;
      if (rv[d]) begin rv_k = k; rdo = rdd[d]; end
      if (rdy[d]) begin ready_k = k; break; end
    end
  endtask

  typedef struct {
    bit          we;
    logic [18:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp;
  } vec_t;

  initial begin
    vec_t tbl [6];
    logic [7:0] rdo;
    logic [18:0] aseen, a;
    int rv_k, ready_k, we_low, oe_low, nr, n, rv_seen;
    bit w;

    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    logic [7:0] rdo, wdat;
    logic [18:0] aseen, a;
    int rv_k, ready_k, we_low, oe_low, nr, n, rv_seen;
    bit w;

    tbl[0] = '{1'b1, 19'h12345, 8'hA5, 8'h00};
    tbl[1] = '{1'b0, 19'h12345, 8'h00, 8'hA5};
    tbl[2] = '{1'b1, 19'h00000, 8'h3C, 8'h00};
    tbl[3] = '{1'b1, 19'h7FFFF, 8'hC3, 8'h00};
    tbl[4] = '{1'b0, 19'h00000, 8'h00, 8'h3C};
    tbl[5] = '{1'b0, 19'h7FFFF, 8'h00, 8'hC3};

    rst = 2'b11; rq_valid = '0; rq_we = '0; rq_addr = '0; rq_wdata = '0;
    repeat (3) @(negedge clk);
    rst = 2'b00;
    @(negedge clk);

    // Reset state
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready_%0d", d), rdy[d], 1);
      chk($sformatf("rst_pins_%0d", d), {ce_b[d], we_b[d], oe_b[d]}, 3'b111);
      chk($sformatf("rst_rdvalid_%0d", d), rv[d], 0);
      chk($sformatf("rst_rddata_%0d", d), rdd[d], 0);
      chk($sformatf("rst_addr_%0d", d), saddr[d], 0);
    end

    // Directed write/read table, default timing
    for (int i = 0; i < 6; i++) begin
      run_access(0, tbl[i].we, tbl[i].addr, tbl[i].wd, rdo, rv_k, ready_k,
                 we_low, oe_low, aseen);
      chk($sformatf("tbl%0d_addr", i), aseen, tbl[i].addr);
      chk($sformatf("tbl%0d_ready_k", i), ready_k, 7);
      if (tbl[i].we) begin
        sb[tbl[i].addr] = tbl[i].wd;
        chk($sformatf("tbl%0d_we_low", i), we_low, 5);
        chk($sformatf("tbl%0d_oe_low", i), oe_low, 0);
        chk($sformatf("tbl%0d_no_rv", i), rv_k, 0);
      end else begin
        chk($sformatf("tbl%0d_rv_k", i), rv_k, 6);
        chk($sformatf("tbl%0d_rdata", i), rdo, tbl[i].exp);
        chk($sformatf("tbl%0d_oe_low", i), oe_low, 5);
        chk($sformatf("tbl%0d_we_low", i), we_low, 0);
      end
    end

    // Back-to-back: read 0x12345 then a write, req_valid held high
    @(negedge clk);
    rq_valid[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = 19'h12345; rq_wdata[0] = 8'h00;
    n = 0;
    while (!rdy[0] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rq_we[0] = 1'b1; rq_addr[0] = 19'h00BAD; rq_wdata[0] = 8'hFF;
    nr = 0; ready_k = 0; rv_k = 0; rdo = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rv[0]) begin rv_k = k; rdo = rdd[0]; end
      if (rdy[0]) begin ready_k = k; break; end
      nr++;
      if (k == 6) begin rq_addr[0] = 19'h00100; rq_wdata[0] = 8'h77; end
    end
    chk("b2b_notready_cycles", nr, 6);
    chk("b2b_second_hs_k", ready_k, 7);
    chk("b2b_read_rv_k", rv_k, 6);
    chk("b2b_read_data", rdo, 8'hA5);
    @(posedge clk); #1;
    rq_valid[0] = 1'b0;
    we_low = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) chk("b2b_write_addr", saddr[0], 19'h00100);
      if (!we_b[0]) we_low++;
      if (rdy[0]) break;
    end
    chk("b2b_write_we_low", we_low, 5);
    sb[19'h00100] = 8'h77;
    run_access(0, 1'b0, 19'h00100, 8'h00, rdo, rv_k, ready_k, we_low, oe_low, aseen);
    chk("b2b_readback_new", rdo, 8'h77);
    run_access(0, 1'b0, 19'h00BAD, 8'h00, rdo, rv_k, ready_k, we_low, oe_low, aseen);
    chk("b2b_garbage_not_written", rdo, 8'h00);

    // Reset in cycle 3 of a read
    @(negedge clk);
    rq_valid[0] = 1'b1; rq_we[0] = 1'b0; rq_addr[0] = 19'h7FFFF;
    n = 0;
    while (!rdy[0] && n < 50) begin @(negedge clk); n++; end
    @(posedge clk); #1;
    rq_valid[0] = 1'b0;
    rv_seen = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (rv[0]) rv_seen++;
    end
    chk("rstmid_oe_active", oe_b[0], 0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("rstmid_pins_idle", {ce_b[0], we_b[0], oe_b[0]}, 3'b111);
    chk("rstmid_ready", rdy[0], 1);
    for (int k = 0; k < 10; k++) begin
      if (rv[0]) rv_seen++;
      @(negedge clk);
    end
    chk("rstmid_no_rdvalid", rv_seen, 0);

    // Random mixed accesses against a scoreboard
    for (int i = 0; i < 1000; i++) begin
      w    = 1'($urandom_range(0, 1));
      a    = {($urandom_range(0, 1) != 0) ? 15'h7FFF : 15'h0000, 4'($urandom_range(0, 15))};
      wdat = 8'($urandom_range(0, 255));
      run_access(0, w, a, wdat, rdo, rv_k, ready_k, we_low, oe_low, aseen);
      if (w) sb[a] = wdat;
      else chk($sformatf("rand%0d_rdata@%05h", i, a), rdo, sb.exists(a) ? sb[a] : 8'h00);
    end

    // Minimum timing instance
    run_access(1, 1'b1, 19'h00010, 8'h55, rdo, rv_k, ready_k, we_low, oe_low, aseen);
    chk("min_write_we_low", we_low, 1);
    chk("min_write_ready_k", ready_k, 3);
    run_access(1, 1'b0, 19'h00010, 8'h00, rdo, rv_k, ready_k, we_low, oe_low, aseen);
    chk("min_read_rv_k", rv_k, 3);
    chk("min_read_data", rdo, 8'h55);
    chk("min_read_oe_low", oe_low, 2);
    chk("min_read_ready_k", ready_k, 4);

    chk("bus_monitor_0", g_dut[0].mon_bad, 0);
    chk("bus_monitor_1", g_dut[1].mon_bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
